fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the CPU: a loadable program memory with a registered read port, a request/stall handshake toward decode, and halt-opcode detection. It replaces the fixed 16-word program ROM. Width and depth are generic. The program is written through a boot-load port before execution starts. Fetches past the populated depth return a NOP with an error flag.

---
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: boot-load, control and fetch handshake between the fetch
// stage and its surroundings. The slave modport is the fetch unit itself.
//
// Handshake: a fetch is taken on a rising edge where FETCH_REQ=1 and STALL=0.
// STALL=1 freezes PROM_OUT/PROM_VALID/FETCH_ERR regardless of FETCH_REQ.
// PROM_VALID=1 means PROM_OUT was loaded by the most recently taken fetch and
// has not yet been consumed by a non-stalled cycle.
interface fetch_unit_if #(
  parameter int INSTR_W = 15,
  parameter int ADDR_W  = 8
);
  logic               LOAD_WE;
  logic [ADDR_W-1:0]  LOAD_ADDR;
  logic [INSTR_W-1:0] LOAD_DATA;
  logic               START;
  logic               RESUME;
  logic [ADDR_W-1:0]  P_COUNT;
  logic               FETCH_REQ;
  logic               STALL;
  logic [INSTR_W-1:0] PROM_OUT;
  logic               PROM_VALID;
  logic               FETCH_ERR;
  logic               HALTED;
  logic               RUNNING;
  logic [1:0]         STATE_DBG;

  modport slave (
    input  LOAD_WE, LOAD_ADDR, LOAD_DATA, START, RESUME,
    input  P_COUNT, FETCH_REQ, STALL,
    output PROM_OUT, PROM_VALID, FETCH_ERR, HALTED, RUNNING, STATE_DBG
  );

  modport master (
    output LOAD_WE, LOAD_ADDR, LOAD_DATA, START, RESUME,
    output P_COUNT, FETCH_REQ, STALL,
    input  PROM_OUT, PROM_VALID, FETCH_ERR, HALTED, RUNNING, STATE_DBG
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: loadable program memory with a registered read port, a
// request/stall handshake toward decode and halt-opcode detection.
// BOOT accepts program writes, RUN serves fetches, HALTED waits for RESUME.
module fetch_unit #(
  parameter int         INSTR_W = 15,
  parameter int         ADDR_W  = 8,
  parameter int         DEPTH   = 16,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic        CLK_FT,
  input  logic        RESET_N,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Index width into the word array; a one-word memory still needs one bit.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Depth widened by one bit so DEPTH = 2^ADDR_W compares correctly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t             state_q;
  logic [INSTR_W-1:0] prom_out_q;
  logic               prom_valid_q;
  logic               fetch_err_q;

  logic [INSTR_W-1:0] mem [DEPTH];

  logic               fetch_in_range;
  logic               load_in_range;
  logic [IDX_W-1:0]   fetch_idx;
  logic [IDX_W-1:0]   load_idx;
  logic [INSTR_W-1:0] fetch_word;
  logic               fetch_is_halt;
  logic               load_wr_en;

  assign fetch_in_range = ({1'b0, bus.P_COUNT} < DEPTH_W);
  assign load_in_range  = ({1'b0, bus.LOAD_ADDR} < DEPTH_W);
  assign fetch_idx      = bus.P_COUNT[IDX_W-1:0];
  assign load_idx       = bus.LOAD_ADDR[IDX_W-1:0];

  // Out-of-range fetches read as an all-zero NOP; only in-range words can halt.
  assign fetch_word    = fetch_in_range ? mem[fetch_idx] : '0;
  assign fetch_is_halt = fetch_in_range && (fetch_word[INSTR_W-1 -: 4] == HALT_OP);
  assign load_wr_en    = (state_q == ST_BOOT) && bus.LOAD_WE && load_in_range;

  // Program memory write: contents survive reset, only the write is suppressed.
  always_ff @(posedge CLK_FT or negedge RESET_N) begin
    if (!RESET_N) begin
    end else if (load_wr_en) begin
      mem[load_idx] <= bus.LOAD_DATA;
    end
  end

  // Control FSM with registered fetch outputs.
  always_ff @(posedge CLK_FT or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_BOOT;
      prom_out_q   <= '0;
      prom_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (bus.START) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.STALL) begin
            if (bus.FETCH_REQ) begin
              prom_out_q   <= fetch_word;
              prom_valid_q <= 1'b1;
              fetch_err_q  <= !fetch_in_range;
              if (fetch_is_halt) begin
                state_q <= ST_HALTED;
              end
            end else begin
              prom_valid_q <= 1'b0;
              fetch_err_q  <= 1'b0;
            end
          end
        end
        ST_HALTED: begin
          // The halt word stays on PROM_OUT; valid drops once decode takes it.
          if (!bus.STALL) begin
            prom_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
          end
          if (bus.RESUME) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign bus.PROM_OUT   = prom_out_q;
  assign bus.PROM_VALID = prom_valid_q;
  assign bus.FETCH_ERR  = fetch_err_q;
  assign bus.HALTED     = (state_q == ST_HALTED);
  assign bus.RUNNING    = (state_q == ST_RUN);
  assign bus.STATE_DBG  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for the documented scenarios, hand
// sequences around asynchronous reset, then randomized traffic compared
// against a behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam int INSTR_W = 15;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 16;

  localparam int MODE_BOOT   = 0;
  localparam int MODE_RUN    = 1;
  localparam int MODE_HALTED = 2;

  logic clk;
  logic rst_n;

  fetch_unit_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

  fetch_unit #(
    .INSTR_W(INSTR_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .HALT_OP(4'b1111)
  ) dut (
    .CLK_FT (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic               we;
    logic [ADDR_W-1:0]  la;
    logic [INSTR_W-1:0] ld;
    logic               st;
    logic               rs;
    logic [ADDR_W-1:0]  pc;
    logic               rq;
    logic               sl;
    logic [INSTR_W-1:0] eo;
    logic               ev;
    logic               ee;
    logic               eh;
    logic               er;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Behavioural model state
  logic [INSTR_W-1:0] mm [DEPTH];
  int                 m_mode;
  logic [INSTR_W-1:0] m_out;
  logic               m_valid;
  logic               m_err;

  function automatic vec_t mk(logic we, int la, int ld, logic st, logic rs,
                              int pc, logic rq, logic sl,
                              int eo, logic ev, logic ee, logic eh, logic er);
    vec_t v;
    v.we = we; v.la = ADDR_W'(la); v.ld = INSTR_W'(ld);
    v.st = st; v.rs = rs; v.pc = ADDR_W'(pc); v.rq = rq; v.sl = sl;
    v.eo = INSTR_W'(eo); v.ev = ev; v.ee = ee; v.eh = eh; v.er = er;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [ADDR_W-1:0] la,
                       input logic [INSTR_W-1:0] ld, input logic st,
                       input logic rs, input logic [ADDR_W-1:0] pc,
                       input logic rq, input logic sl);
    bus.LOAD_WE   = we;
    bus.LOAD_ADDR = la;
    bus.LOAD_DATA = ld;
    bus.START     = st;
    bus.RESUME    = rs;
    bus.P_COUNT   = pc;
    bus.FETCH_REQ = rq;
    bus.STALL     = sl;
  endtask

  task automatic model_reset();
    m_mode  = MODE_BOOT;
    m_out   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // One rising edge of the reference behaviour, from the inputs being driven.
  task automatic model_edge();
    int addr;
    addr = int'(bus.P_COUNT);
    if (m_mode == MODE_BOOT) begin
      if (bus.LOAD_WE && int'(bus.LOAD_ADDR) < DEPTH) mm[int'(bus.LOAD_ADDR)] = bus.LOAD_DATA;
      if (bus.START) m_mode = MODE_RUN;
    end else if (m_mode == MODE_RUN) begin
      if (!bus.STALL) begin
        if (bus.FETCH_REQ) begin
          m_valid = 1'b1;
          if (addr < DEPTH) begin
            m_out = mm[addr];
            m_err = 1'b0;
            if ((int'(m_out) >> (INSTR_W - 4)) == 15) m_mode = MODE_HALTED;
          end else begin
            m_out = '0;
            m_err = 1'b1;
          end
        end else begin
          m_valid = 1'b0;
          m_err   = 1'b0;
        end
      end
    end else begin
      if (!bus.STALL) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
      end
      if (bus.RESUME) m_mode = MODE_RUN;
    end
  endtask

  task automatic check(input string name, input logic [INSTR_W-1:0] eo,
                       input logic ev, input logic ee, input logic eh, input logic er);
    n_vec++;
    if ({bus.PROM_OUT, bus.PROM_VALID, bus.FETCH_ERR, bus.HALTED, bus.RUNNING}
        !== {eo, ev, ee, eh, er}) begin
      n_bad++;
      $display("FAIL %s: got out=%h valid=%b err=%b halted=%b running=%b, want out=%h valid=%b err=%b halted=%b running=%b",
               name, bus.PROM_OUT, bus.PROM_VALID, bus.FETCH_ERR, bus.HALTED, bus.RUNNING,
               eo, ev, ee, eh, er);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_out, m_valid, m_err, m_mode == MODE_HALTED, m_mode == MODE_RUN);
  endtask

  // Apply one cycle of inputs, clock it, then compare just after the edge.
  task automatic step(input logic we, input logic [ADDR_W-1:0] la,
                      input logic [INSTR_W-1:0] ld, input logic st,
                      input logic rs, input logic [ADDR_W-1:0] pc,
                      input logic rq, input logic sl, input string name);
    drive(we, la, ld, st, rs, pc, rq, sl);
    @(posedge clk);
    model_edge();
    #1;
    check_model(name);
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check(name, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //        we la  ld       st rs pc rq sl   eo       ev ee eh er
    tbl.push_back(mk(1, 0,  'h4800, 0, 0, 0, 0, 0,  'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1,  'h4001, 0, 0, 0, 0, 0,  'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2,  'h0ABC, 0, 0, 0, 0, 0,  'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4,  'h0004, 0, 0, 0, 0, 0,  'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 15, 'h0F0F, 0, 0, 0, 0, 0,  'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 20, 'h5555, 0, 0, 0, 0, 0,  'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3,  'h7800, 1, 0, 0, 1, 0,  'h0000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 0, 1, 0,  'h4800, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 1, 1, 0,  'h4001, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 2, 1, 1,  'h4001, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 5, 1, 1,  'h4001, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 6, 1, 1,  'h4001, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 2, 1, 0,  'h0ABC, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 0, 0, 0,  'h0ABC, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 20, 1, 0, 'h0000, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 0, 0, 1,  'h0000, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 15, 1, 0, 'h0F0F, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 4, 1, 0,  'h0004, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 0, 0, 0,  'h0004, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0,  'h1234, 0, 0, 0, 0, 0,  'h0004, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 1, 0, 1, 0,  'h4800, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 3, 1, 0,  'h7800, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0,  0,      0, 0, 0, 1, 1,  'h7800, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0,  0,      0, 0, 0, 1, 0,  'h7800, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0,  0,      1, 0, 0, 1, 0,  'h7800, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0,  0,      0, 1, 0, 0, 0,  'h7800, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 0, 1, 0,  'h4800, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  0,      0, 0, 0, 0, 0,  'h4800, 0, 0, 0, 1));

    // Reset block
    rst_n = 1'b0;
    drive(0, '0, '0, 0, 0, '0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; the model tracks along so later phases know the memory.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].la, tbl[i].ld, tbl[i].st, tbl[i].rs,
            tbl[i].pc, tbl[i].rq, tbl[i].sl);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ev, tbl[i].ee, tbl[i].eh, tbl[i].er);
    end

    // Reset mid-cycle, with a write held across an edge during reset (lost).
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 8'd0, 15'h1234, 0, 0, '0, 1, 0);
    @(posedge clk);
    #1;
    check("rst_hold", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Retention: START without reloading, memory still holds the old program.
    step(0, '0, '0, 1, 0, '0, 0, 0, "restart");
    step(0, '0, '0, 0, 0, 8'd0, 1, 0, "retain0");
    check("retain0_value", 15'h4800, 1'b1, 1'b0, 1'b0, 1'b1);
    step(0, '0, '0, 0, 0, 8'd1, 1, 0, "retain1");
    step(0, '0, '0, 0, 0, 8'd3, 1, 0, "retain_halt");

    // Randomized phase: fresh random program, then random traffic.
    async_reset("rand_rst");
    for (int a = 0; a < DEPTH; a++) begin
      step(1, ADDR_W'(a), INSTR_W'($urandom_range(0, 32767)), 0, 0,
           ADDR_W'($urandom_range(0, 23)), 1'($urandom_range(0, 1)), 0, "rand_load");
    end
    step(1, ADDR_W'($urandom_range(16, 255)), INSTR_W'($urandom_range(0, 32767)),
         1, 0, '0, 0, 0, "rand_start");
    for (int c = 0; c < 1500; c++) begin
      step(1'($urandom_range(0, 3) == 0),
           ADDR_W'($urandom_range(0, 31)),
           INSTR_W'($urandom_range(0, 32767)),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 7) == 0),
           ADDR_W'($urandom_range(0, 23)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) == 0),
           "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
